// File: rtl/mem_lsu_pkg.sv
// Shared types, opcode encodings and byte-lane constants for the MEM stage.
package mem_lsu_pkg;

    typedef logic [7:0]  alu_op_t;    // AluOpBus
    typedef logic [31:0] reg_t;       // RegBus
    typedef logic [4:0]  reg_addr_t;  // RegAddrBus

    localparam reg_addr_t NOPRegAddr = 5'd0;
    localparam reg_t      ZeroWord   = 32'd0;

    localparam alu_op_t EXE_LB_OP  = 8'b1110_0000;
    localparam alu_op_t EXE_LH_OP  = 8'b1110_0001;
    localparam alu_op_t EXE_LW_OP  = 8'b1110_0011;
    localparam alu_op_t EXE_LBU_OP = 8'b1110_0100;
    localparam alu_op_t EXE_LHU_OP = 8'b1110_0101;
    localparam alu_op_t EXE_SB_OP  = 8'b1110_1000;
    localparam alu_op_t EXE_SH_OP  = 8'b1110_1001;
    localparam alu_op_t EXE_SW_OP  = 8'b1110_1011;

    // Big-endian lanes: byte offset 0 lives in bits 31:24 (sel bit 3).
    localparam logic [3:0] SelNone = 4'b0000;
    localparam logic [3:0] SelB0   = 4'b1000;
    localparam logic [3:0] SelB1   = 4'b0100;
    localparam logic [3:0] SelB2   = 4'b0010;
    localparam logic [3:0] SelB3   = 4'b0001;
    localparam logic [3:0] SelH0   = 4'b1100;
    localparam logic [3:0] SelH1   = 4'b0011;
    localparam logic [3:0] SelWord = 4'b1111;

    typedef enum logic {
        StIdle,
        StBusy
    } lsu_state_e;

    function automatic logic is_load_op(alu_op_t op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store_op(alu_op_t op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus request/acknowledge interface between the LSU (master) and memory (slave).
interface mem_lsu_if;
    import mem_lsu_pkg::*;

    logic       dbus_req;
    logic       dbus_we;
    reg_t       dbus_addr;
    logic [3:0] dbus_sel;
    reg_t       dbus_wdata;
    reg_t       dbus_rdata;
    logic       dbus_ack;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
        input  dbus_rdata, dbus_ack
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
        output dbus_rdata, dbus_ack
    );

endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: request-side byte selects, store replication and
// misalignment; response-side lane extraction with sign/zero extension.
module mem_align
    import mem_lsu_pkg::*;
(
    input  alu_op_t    req_op_i,
    input  logic [1:0] req_off_i,
    input  reg_t       req_wdata_i,
    output logic [3:0] sel_o,
    output reg_t       wdata_o,
    output logic       misalign_o,
    input  alu_op_t    rsp_op_i,
    input  logic [1:0] rsp_off_i,
    input  reg_t       rdata_i,
    output reg_t       rdata_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Request side: lanes, replicated store data and alignment check.
    always_comb begin
        sel_o      = SelNone;
        wdata_o    = ZeroWord;
        misalign_o = 1'b0;
        case (req_op_i)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
                wdata_o = {4{req_wdata_i[7:0]}};
                case (req_off_i)
                    2'b00:   sel_o = SelB0;
                    2'b01:   sel_o = SelB1;
                    2'b10:   sel_o = SelB2;
                    default: sel_o = SelB3;
                endcase
            end
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
                wdata_o    = {2{req_wdata_i[15:0]}};
                misalign_o = req_off_i[0];
                sel_o      = req_off_i[1] ? SelH1 : SelH0;
            end
            EXE_LW_OP, EXE_SW_OP: begin
                wdata_o    = req_wdata_i;
                misalign_o = |req_off_i;
                sel_o      = SelWord;
            end
            default: ;
        endcase
    end

    // Response side: pick the addressed lane and extend to a full word.
    always_comb begin
        byte_v  = 8'h00;
        half_v  = rsp_off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        rdata_o = ZeroWord;
        case (rsp_off_i)
            2'b00:   byte_v = rdata_i[31:24];
            2'b01:   byte_v = rdata_i[23:16];
            2'b10:   byte_v = rdata_i[15:8];
            default: byte_v = rdata_i[7:0];
        endcase
        case (rsp_op_i)
            EXE_LB_OP:  rdata_o = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: rdata_o = {24'h0, byte_v};
            EXE_LH_OP:  rdata_o = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: rdata_o = {16'h0, half_v};
            EXE_LW_OP:  rdata_o = rdata_i;
            default:    rdata_o = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage merged with the MEM/WB register: passes ALU results through and runs
// load/store transactions on the data bus with a timeout.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TMO_W          = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  reg_addr_t  mem_waddr,
    input  logic       mem_wreg,
    input  reg_t       mem_wdata,
    input  alu_op_t    mem_aluop,
    input  reg_t       mem_addr,
    input  reg_t       mem_reg2,
    input  logic       flush,
    output logic       stallreq,
    mem_lsu_if.master  dbus,
    output reg_addr_t  wb_waddr,
    output logic       wb_wreg,
    output reg_t       wb_wdata,
    output logic       excp_adel,
    output logic       excp_ades,
    output logic       bus_err
);

    localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    alu_op_t          op_q, op_d;
    logic [1:0]       off_q, off_d;
    reg_addr_t        waddr_q, waddr_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    reg_t             addr_q, addr_d;
    logic [3:0]       sel_q, sel_d;
    reg_t             bwdata_q, bwdata_d;
    reg_addr_t        wb_waddr_q, wb_waddr_d;
    logic             wb_wreg_q, wb_wreg_d;
    reg_t             wb_wdata_q, wb_wdata_d;
    logic             adel_q, adel_d;
    logic             ades_q, ades_d;
    logic             bus_err_q, bus_err_d;

    logic       is_load, is_store, timeout;
    logic       misalign;
    logic [3:0] req_sel;
    reg_t       req_wdata;
    reg_t       rsp_data;

    assign is_load  = is_load_op(mem_aluop);
    assign is_store = is_store_op(mem_aluop);
    assign timeout  = (state_q == StBusy) && (cnt_q == TmoLast);

    mem_align u_align (
        .req_op_i    (mem_aluop),
        .req_off_i   (mem_addr[1:0]),
        .req_wdata_i (mem_reg2),
        .sel_o       (req_sel),
        .wdata_o     (req_wdata),
        .misalign_o  (misalign),
        .rsp_op_i    (op_q),
        .rsp_off_i   (off_q),
        .rdata_i     (dbus.dbus_rdata),
        .rdata_o     (rsp_data)
    );

    // Next-state, stall request and writeback selection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        abort_d    = abort_q;
        op_d       = op_q;
        off_d      = off_q;
        waddr_d    = waddr_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        bwdata_d   = bwdata_q;
        wb_waddr_d = wb_waddr_q;
        wb_wreg_d  = 1'b0;
        wb_wdata_d = wb_wdata_q;
        adel_d     = 1'b0;
        ades_d     = 1'b0;
        bus_err_d  = 1'b0;
        stallreq   = 1'b0;
        case (state_q)
            StIdle: begin
                wb_waddr_d = mem_waddr;
                wb_wdata_d = mem_wdata;
                wb_wreg_d  = mem_wreg && !flush && !is_load && !is_store;
                if (!flush && (is_load || is_store)) begin
                    if (misalign) begin
                        adel_d = is_load;
                        ades_d = is_store;
                    end else begin
                        stallreq = 1'b1;
                        state_d  = StBusy;
                        cnt_d    = '0;
                        abort_d  = 1'b0;
                        op_d     = mem_aluop;
                        off_d    = mem_addr[1:0];
                        waddr_d  = mem_waddr;
                        req_d    = 1'b1;
                        we_d     = is_store;
                        addr_d   = {mem_addr[31:2], 2'b00};
                        sel_d    = req_sel;
                        bwdata_d = req_wdata;
                    end
                end
            end
            StBusy: begin
                // Flush never shortens the bus transaction; it only discards the result.
                stallreq = !dbus.dbus_ack && !timeout;
                cnt_d    = cnt_q + TMO_W'(1);
                if (flush) begin
                    abort_d = 1'b1;
                end
                if (dbus.dbus_ack) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (is_load_op(op_q) && !abort_q && !flush) begin
                        wb_wreg_d  = 1'b1;
                        wb_waddr_d = waddr_q;
                        wb_wdata_d = rsp_data;
                    end
                end else if (timeout) begin
                    state_d   = StIdle;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    bus_err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, bus and writeback registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            op_q       <= '0;
            off_q      <= 2'b00;
            waddr_q    <= NOPRegAddr;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= ZeroWord;
            sel_q      <= SelNone;
            bwdata_q   <= ZeroWord;
            wb_waddr_q <= NOPRegAddr;
            wb_wreg_q  <= 1'b0;
            wb_wdata_q <= ZeroWord;
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            op_q       <= op_d;
            off_q      <= off_d;
            waddr_q    <= waddr_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            bwdata_q   <= bwdata_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
            adel_q     <= adel_d;
            ades_q     <= ades_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign dbus.dbus_req   = req_q;
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_addr  = addr_q;
    assign dbus.dbus_sel   = sel_q;
    assign dbus.dbus_wdata = bwdata_q;
    assign wb_waddr        = wb_waddr_q;
    assign wb_wreg         = wb_wreg_q;
    assign wb_wdata        = wb_wdata_q;
    assign excp_adel       = adel_q;
    assign excp_ades       = ades_q;
    assign bus_err         = bus_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu: the bench acts as bus slave and predicts every
// observable outcome from operand size, offset and ack timing.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int T = 4;
    localparam logic [7:0] OpOr = 8'b0010_0101;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] mem_waddr;
    logic       mem_wreg;
    logic [31:0] mem_wdata, mem_addr, mem_reg2;
    logic [7:0] mem_aluop;
    logic       flush;
    logic       stallreq;
    logic [4:0] wb_waddr;
    logic       wb_wreg;
    logic [31:0] wb_wdata;
    logic       excp_adel, excp_ades, bus_err;

    int n_checks = 0;
    int n_pass   = 0;

    mem_lsu_if bus ();

    mem_lsu #(.TIMEOUT_CYCLES(T), .TMO_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_waddr (mem_waddr),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_aluop (mem_aluop),
        .mem_addr  (mem_addr),
        .mem_reg2  (mem_reg2),
        .flush     (flush),
        .stallreq  (stallreq),
        .dbus      (bus.master),
        .wb_waddr  (wb_waddr),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata),
        .excp_adel (excp_adel),
        .excp_ades (excp_ades),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Access size in bytes, 0 for non-memory ops.
    function automatic int op_size(logic [7:0] op);
        if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
        if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
        return 0;
    endfunction

    function automatic bit op_ld(logic [7:0] op);
        return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
               op == EXE_LHU_OP || op == EXE_LW_OP;
    endfunction

    function automatic logic [3:0] model_sel(int size, int off);
        logic [3:0] m;
        m = (size == 4) ? 4'b1111 : (size == 2) ? 4'b1100 : 4'b1000;
        return m >> off;
    endfunction

    function automatic logic [31:0] model_wdata(int size, logic [31:0] d);
        if (size == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (size == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(logic [7:0] op, int off, logic [31:0] d);
        int size, shift;
        logic [31:0] mask, raw;
        bit sgn;
        size  = op_size(op);
        shift = 8 * (4 - size - off);
        mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        raw   = (d >> shift) & mask;
        sgn   = (op == EXE_LB_OP || op == EXE_LH_OP);
        if (sgn && raw[8 * size - 1]) raw = raw | ~mask;
        return raw;
    endfunction

    // One instruction through MEM. ack_dly >= T means the slave never acks;
    // fl_busy is the BUSY cycle index carrying a flush pulse (-1 for none).
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] wdat, input logic [4:0] waddr, input logic wreg,
                          input logic [31:0] rdata, input int ack_dly, input bit fl_idle,
                          input int fl_busy);
        int  size, off;
        bit  ld, mis, go, aborted, done, exp_wreg;
        size = op_size(op);
        off  = int'(addr[1:0]);
        ld   = op_ld(op);
        mis  = (size != 0) && ((off % size) != 0);
        go   = (size != 0) && !mis && !fl_idle;
        mem_aluop = op; mem_addr = addr; mem_reg2 = reg2; mem_wdata = wdat;
        mem_waddr = waddr; mem_wreg = wreg; flush = fl_idle;
        bus.dbus_ack = 1'b0;
        #1;
        check_eq("stall_issue", {31'h0, stallreq}, {31'h0, go});
        @(posedge clk); #1;
        flush = 1'b0;
        if (!go) begin
            exp_wreg = (size == 0) && wreg && !fl_idle;
            check_eq("req_idle", {31'h0, bus.dbus_req}, 32'h0);
            check_eq("adel", {31'h0, excp_adel}, {31'h0, mis && ld && !fl_idle});
            check_eq("ades", {31'h0, excp_ades}, {31'h0, mis && !ld && !fl_idle});
            check_eq("bus_err_idle", {31'h0, bus_err}, 32'h0);
            check_eq("wb_wreg", {31'h0, wb_wreg}, {31'h0, exp_wreg});
            if (exp_wreg) begin
                check_eq("wb_waddr", {27'h0, wb_waddr}, {27'h0, waddr});
                check_eq("wb_wdata", wb_wdata, wdat);
            end
            return;
        end
        check_eq("req_issue", {31'h0, bus.dbus_req}, 32'h1);
        check_eq("we", {31'h0, bus.dbus_we}, {31'h0, !ld});
        check_eq("wb_bubble", {31'h0, wb_wreg}, 32'h0);
        if (!ld) check_eq("bus_wdata", bus.dbus_wdata, model_wdata(size, reg2));
        aborted = 1'b0;
        done    = 1'b0;
        for (int k = 0; k < T; k++) begin
            if (k == fl_busy) begin flush = 1'b1; aborted = 1'b1; end
            if (k == ack_dly) begin bus.dbus_ack = 1'b1; bus.dbus_rdata = rdata; end
            #1;
            check_eq("stall_busy", {31'h0, stallreq}, {31'h0, (k != ack_dly) && (k != T - 1)});
            check_eq("req_hold", {31'h0, bus.dbus_req}, 32'h1);
            check_eq("addr_hold", bus.dbus_addr, addr & 32'hFFFF_FFFC);
            check_eq("sel_hold", {28'h0, bus.dbus_sel}, {28'h0, model_sel(size, off)});
            check_eq("no_err_busy", {31'h0, bus_err}, 32'h0);
            @(posedge clk); #1;
            flush = 1'b0;
            bus.dbus_ack = 1'b0;
            if (k == ack_dly) begin
                done = 1'b1;
                check_eq("req_done", {31'h0, bus.dbus_req}, 32'h0);
                check_eq("no_err_ack", {31'h0, bus_err}, 32'h0);
                check_eq("wb_wreg_ack", {31'h0, wb_wreg}, {31'h0, ld && !aborted});
                if (ld && !aborted) begin
                    check_eq("ld_waddr", {27'h0, wb_waddr}, {27'h0, waddr});
                    check_eq("ld_data", wb_wdata, model_load(op, off, rdata));
                end
                break;
            end
        end
        if (!done) begin
            check_eq("req_tmo", {31'h0, bus.dbus_req}, 32'h0);
            check_eq("bus_err", {31'h0, bus_err}, 32'h1);
            check_eq("wb_wreg_tmo", {31'h0, wb_wreg}, 32'h0);
        end
    endtask

    logic [7:0] ops [9];

    initial begin
        ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, OpOr};
        rst = 1'b0;
        mem_waddr = '0; mem_wreg = 1'b0; mem_wdata = '0; mem_aluop = '0;
        mem_addr = '0; mem_reg2 = '0; flush = 1'b0;
        bus.dbus_ack = 1'b0; bus.dbus_rdata = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req", {31'h0, bus.dbus_req}, 32'h0);
        check_eq("rst_we", {31'h0, bus.dbus_we}, 32'h0);
        check_eq("rst_addr", bus.dbus_addr, 32'h0);
        check_eq("rst_sel", {28'h0, bus.dbus_sel}, 32'h0);
        check_eq("rst_bwdata", bus.dbus_wdata, 32'h0);
        check_eq("rst_wb", {wb_waddr, wb_wreg, excp_adel, excp_ades, bus_err}, 32'h0);
        check_eq("rst_wbdata", wb_wdata, 32'h0);
        rst = 1'b0;

        run_op(OpOr, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 32'h0, 0, 1'b0, -1);
        run_op(EXE_LB_OP, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1, 32'h1122_3380, 0, 1'b0, -1);
        run_op(EXE_SH_OP, 32'h202, 32'h0000_BEEF, 32'h0, 5'd0, 1'b0, 32'h0, 1, 1'b0, -1);
        run_op(EXE_LW_OP, 32'h201, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0, 0, 1'b0, -1);
        run_op(EXE_LW_OP, 32'h300, 32'h0, 32'h0, 5'd4, 1'b1, 32'hDEAD_BEEF, 9, 1'b0, -1);
        run_op(EXE_LW_OP, 32'h304, 32'h0, 32'h0, 5'd4, 1'b1, 32'hCAFE_F00D, T - 1, 1'b0, -1);
        run_op(EXE_LHU_OP, 32'h402, 32'h0, 32'h0, 5'd9, 1'b1, 32'h1234_8765, 3, 1'b0, 0);
        run_op(EXE_SW_OP, 32'h500, 32'h0, 32'h0, 5'd1, 1'b1, 32'h0, 0, 1'b1, -1);

        // Asynchronous reset in the middle of a transaction.
        mem_aluop = EXE_LW_OP; mem_addr = 32'h600; mem_wreg = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        check_eq("req_pre_rst", {31'h0, bus.dbus_req}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check_eq("req_async_rst", {31'h0, bus.dbus_req}, 32'h0);
        check_eq("sel_async_rst", {28'h0, bus.dbus_sel}, 32'h0);
        mem_aluop = OpOr; mem_wreg = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 200; i++) begin
            logic [7:0] op;
            int fb;
            op = ops[$urandom_range(0, 8)];
            fb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T - 1)) : -1;
            run_op(op, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                   $urandom, int'($urandom_range(0, T + 1)), $urandom_range(0, 9) == 0, fb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
